// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and divisor width
package uart_pkg;

  localparam int BAUD_W = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'b000,
    RX_START  = 3'b001,
    RX_DATA   = 3'b010,
    RX_PARITY = 3'b011,
    RX_STOP   = 3'b100
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'b000,
    TX_START  = 3'b001,
    TX_DATA   = 3'b010,
    TX_PARITY = 3'b011,
    TX_STOP   = 3'b100
  } tx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rxd synchroniser with falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxd_in,
  output logic rxd_s,
  output logic fall_edge
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  always_comb begin
    sync1_d = rxd_in;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  // Idle line level is high, so reset to 1 to avoid a spurious start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign rxd_s     = sync2_q;
  assign fall_edge = ~sync2_q & dly_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start detect, bit sampling, status flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int D = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BAUD_W-1:0] baud_rate_param,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              parity_mode,
  input  logic              big_endian,
  input  logic              uart_disable,
  input  logic              rxd_in,
  input  logic              rx_read,
  output logic [7:0]        rx_data,
  output logic              rx_rb8,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              rx_full,
  output logic              rx_irq,
  output logic [2:0]        rx_state
);

  // D is accepted for drop-in compatibility with uart_tx; no delays are modelled.
  if (D < 0) begin : g_neg_delay
  end

  logic rxd_s, fall_edge;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rxd_in    (rxd_in),
    .rxd_s     (rxd_s),
    .fall_edge (fall_edge)
  );

  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] count_q, count_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        sr_q, sr_d;
  logic              rb8_q, rb8_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_rb8_q, rx_rb8_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              rx_full_q, rx_full_d;
  logic              rx_irq_q, rx_irq_d;

  logic [BAUD_W-1:0] half;
  logic              at_bit_end;
  logic              done;
  logic              exp_par;

  assign half       = baud_rate_param >> 1;
  assign at_bit_end = (count_q == baud_rate_param);
  assign exp_par    = parity_odd ? ^sr_q : ~^sr_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    rb8_d     = rb8_q;
    done      = 1'b0;

    case (state_q)
      RX_IDLE: begin
        count_d = '0;
        if (fall_edge) state_d = RX_START;
      end
      RX_START: begin
        if (count_q == half) begin
          count_d = '0;
          state_d = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (at_bit_end) begin
          count_d   = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          sr_d      = big_endian ? {sr_q[6:0], rxd_s} : {rxd_s, sr_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = parity_en ? RX_PARITY : RX_STOP;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      RX_PARITY: begin
        if (at_bit_end) begin
          count_d = '0;
          rb8_d   = rxd_s;
          state_d = RX_STOP;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (at_bit_end) begin
          count_d = '0;
          done    = 1'b1;
          state_d = RX_IDLE;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (uart_disable) begin
      state_d   = RX_IDLE;
      count_d   = '0;
      bit_cnt_d = '0;
      done      = 1'b0;
    end
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_rb8_d     = rx_rb8_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    rx_full_d    = rx_full_q;
    rx_irq_d     = 1'b0;

    // A read landing on the completion edge consumes the old character, so no overrun.
    if (done) begin
      rx_data_d    = sr_q;
      rx_rb8_d     = parity_en & rb8_q;
      frame_err_d  = ~rxd_s;
      parity_err_d = parity_en & ~parity_mode & (rb8_q != exp_par);
      rx_irq_d     = 1'b1;
      rx_full_d    = 1'b1;
      overrun_d    = ~rx_read & (overrun_q | rx_full_q);
    end else if (rx_read) begin
      rx_full_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      count_q      <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      rb8_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_rb8_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rx_full_q    <= 1'b0;
      rx_irq_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      rb8_q        <= rb8_d;
      rx_data_q    <= rx_data_d;
      rx_rb8_q     <= rx_rb8_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      rx_full_q    <= rx_full_d;
      rx_irq_q     <= rx_irq_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_rb8      = rx_rb8_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_full     = rx_full_q;
  assign rx_irq      = rx_irq_q;
  assign rx_state    = state_q;

endmodule
